instruction_queue: RTL
======================

// Module: instruction_queue
// PURPOSE
//  Receiving end of the IR->IQ handshake: buffers decoded control words and their rvfi words from the
//  fetch/decode stage in program order, and presents the oldest entry to the dispatch stage (RS/ROB
//  allocation). Acks each IR load combinationally. Empties on a branch-mispredict flush.
// PARAMETERS
//  DEPTH     8              entries; power of two, >= 2
//  PTR_W     $clog2(DEPTH)  localparam, pointer width; count is PTR_W+1 bits
// PORTS
//  clk           in   1               rising-edge clock
//  rst           in   1               synchronous, active-high reset
//  iq_ir_itf     if   IQ_2_IR.IQ_SIG  ld_iq (in,1), control_word (in,ctl_word), rvfi (in,rvfi_word)
//  iq_ack        out  1               entry accepted this cycle
//  flush_ip      in   1               mispredict flush; discard all entries
//  issue_ready   in   1               dispatch can take the head entry this cycle
//  issue_valid   out  1               head entry valid
//  issue_word    out  ctl_word        head control word
//  issue_rvfi    out  rvfi_word       head rvfi word
//  full          out  1               count == DEPTH
//  empty         out  1               count == 0
//  count         out  PTR_W+1         occupied entries
// BEHAVIOUR
//  - Circular buffer: head_ptr (read), tail_ptr (write), count register. Pointers wrap DEPTH-1 -> 0.
//  - Reset: head_ptr=0, tail_ptr=0, count=0; so iq_ack=0, issue_valid=0, full=0, empty=1, count=0.
//    Entry storage is not reset. Reset mid-operation has the same effect as a flush, plus it forces
//    iq_ack=0 in the reset cycle.
//  - iq_ack = ld_iq & ~full & ~flush_ip & ~rst. It is purely combinational, same cycle as ld_iq,
//    because IR samples it in CREATE/STALL to leave that state.
//    IR holds ld_iq and control_word stable until it sees ack.
//  - enq = ld_iq & iq_ack: write {control_word, rvfi} at tail_ptr; tail_ptr++.
//  - issue_valid = ~empty & ~flush_ip. issue_word and issue_rvfi = entry[head_ptr]. These are read
//    combinationally from registered storage.
//  - deq = issue_valid & issue_ready: head_ptr++ at the clock edge. Dispatch consumes the entry in the
//    same cycle.
//  - Latency: an entry enqueued at edge N is visible on issue_* after edge N. There is no same-cycle
//    bypass from ld_iq to issue_*.
//  - count_next = count + enq - deq. Both may fire in the same cycle, including when count==1.
//  - Full: no ack, even if a dequeue occurs in the same cycle. The IR retries the next cycle, which
//    avoids an ack->ready combinational path.
//  - Empty: issue_valid=0; issue_ready is ignored.
//  - Flush (highest priority after rst): head_ptr<=0, tail_ptr<=0, count<=0.
//    enq and deq are both suppressed in the flush cycle. The IR's STALL_FLUSH_TWO load is only
//    accepted after flush_ip drops.
//  - Entries are never reordered or modified. Branch/JALR words pass through unchanged
//    (pc, rd prediction bits intact).
// STRUCTURE
//  - Package tomasula_types: typedef iq_entry_t {ctl_word cw; rvfi_word rvfi;} and localparam
//    IQ_DEPTH=8.
//  - Sub-module iq_storage #(DEPTH): array of iq_entry_t with one sync write port (we, waddr, wdata)
//    and one async read port (raddr -> rdata).
//  - Top level holds the pointers, count, ack/valid logic and flush priority.
// TESTING (DEPTH=8)
//  1 Reset then idle.
//    -> iq_ack=0, issue_valid=0, empty=1, count=0.
//    ld_iq=1 with cw.pc=0x64 -> iq_ack=1 in the same cycle; next cycle issue_valid=1,
//    issue_word.pc=0x64, count=1.
//  2 issue_ready=0, ld_iq held for 9 words pc=0x64..0x84.
//    -> 8 acks, full=1; 9th ld_iq sees iq_ack=0.
//    Raise issue_ready: words drain in order 0x64..0x80; 0x84 is acked the cycle after full drops.
//  3 count=1, ld_iq=1 and issue_ready=1 in the same cycle.
//    -> count stays 1; next head is the new word; no bubble on issue_valid.
//  4 Wrap-around: 20 enqueue/dequeue pairs with random issue_ready stalls.
//    -> scoreboard order matches; pointers wrap 7->0 with no loss or duplication.
//  5 count=5, flush_ip=1 together with ld_iq=1 and issue_ready=1.
//    -> iq_ack=0, issue_valid=0 that cycle; next cycle count=0, empty=1; the following ld_iq is acked.
//  6 rst asserted while count=6.
//    -> next cycle count=0, empty=1, issue_valid=0, iq_ack=0 during the rst cycle.

Source files
------------

// File: rtl/instruction_queue_pkg.sv
// Shared types for the out-of-order core front end: decoded control words,
// RVFI trace words and the instruction-queue entry that bundles them.
package tomasula_types;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic        is_branch;
    logic        pred_taken;
    logic        is_jalr;
  } ctl_word;

  typedef struct packed {
    logic [31:0] order;
    logic [31:0] insn;
  } rvfi_word;

  typedef struct packed {
    ctl_word  cw;
    rvfi_word rvfi;
  } iq_entry_t;

endpackage

// File: rtl/iq_2_ir_if.sv
// Handshake bundle from the IR (fetch/decode) stage into the instruction queue.
// The acknowledge travels back as a separate port on the queue.
interface IQ_2_IR;
  import tomasula_types::*;

  logic     ld_iq;
  ctl_word  control_word;
  rvfi_word rvfi;

  modport IQ_SIG (input ld_iq, control_word, rvfi);
  modport IR_SIG (output ld_iq, control_word, rvfi);
endinterface

// File: rtl/iq_storage.sv
// Entry storage for the instruction queue: one synchronous write port and one
// asynchronous read port, so the head entry is visible in the cycle it is addressed.
module iq_storage
  import tomasula_types::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  iq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output iq_entry_t     rdata
);

  // Contents are never reset; validity is tracked by the pointers and count.
  iq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_queue.sv
// In-order circular buffer between decode and dispatch. Acks loads combinationally,
// presents the oldest entry, and empties on reset or a mispredict flush.
module instruction_queue
  import tomasula_types::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  IQ_2_IR.IQ_SIG         iq_ir_itf,
  output logic           iq_ack,
  input  logic           flush_ip,
  input  logic           issue_ready,
  output logic           issue_valid,
  output ctl_word        issue_word,
  output rvfi_word       issue_rvfi,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  logic [PTR_W-1:0] head_ptr_reg, head_ptr_next;
  logic [PTR_W-1:0] tail_ptr_reg, tail_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             enq, deq;
  iq_entry_t        wr_entry, head_entry;

  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Full blocks the ack even when a dequeue is happening, keeping ready off the ack path.
  assign iq_ack = iq_ir_itf.ld_iq & ~full & ~flush_ip & ~rst;
  assign enq    = iq_ir_itf.ld_iq & iq_ack;

  assign issue_valid = ~empty & ~flush_ip;
  assign deq         = issue_valid & issue_ready;

  assign wr_entry.cw   = iq_ir_itf.control_word;
  assign wr_entry.rvfi = iq_ir_itf.rvfi;

  assign issue_word = head_entry.cw;
  assign issue_rvfi = head_entry.rvfi;

  // Power-of-two depth lets the pointers wrap naturally on overflow.
  always_comb begin
    head_ptr_next = head_ptr_reg;
    tail_ptr_next = tail_ptr_reg;
    count_next    = count_reg;
    if (flush_ip) begin
      head_ptr_next = '0;
      tail_ptr_next = '0;
      count_next    = '0;
    end else begin
      if (enq) begin
        tail_ptr_next = tail_ptr_reg + 1'b1;
      end
      if (deq) begin
        head_ptr_next = head_ptr_reg + 1'b1;
      end
      count_next = count_reg + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      head_ptr_reg <= head_ptr_next;
      tail_ptr_reg <= tail_ptr_next;
      count_reg    <= count_next;
    end
  end

  iq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (enq),
    .waddr (tail_ptr_reg),
    .wdata (wr_entry),
    .raddr (head_ptr_reg),
    .rdata (head_entry)
  );

endmodule
